// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
//   uart_arb_state_e : arbiter FSM states (IDLE, START, WAIT), 2-bit encoding
//   UART_DATA_W      : default byte width
//   UART_MAX_REQ     : largest supported requester count
//   rr_wrap_inc()    : increment an index with wrap at n-1
package uart_pkg;

    localparam int unsigned UART_DATA_W  = 8;
    localparam int unsigned UART_MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } uart_arb_state_e;

    function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotating priority encoder.
//   req     : request vector, one bit per requester
//   ptr     : highest-priority index for this pick
//   gnt_idx : first set req bit at or above ptr, wrapping from N_REQ-1 to 0
//   any     : at least one req bit is set
module uart_rr_pick #(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [$clog2(N_REQ)-1:0] gnt_idx,
    output logic                     any
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    always_comb begin
        int unsigned idx;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = (32'(ptr) + i) % N_REQ;
            if (!any && req[idx]) begin
                any     = 1'b1;
                gnt_idx = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ requesters.
// Accepts one byte per grant, pulses tx_start, then holds the transmitter
// until tx_done_tick.
//   clk, rst_n    : system clock, asynchronous active-low reset
//   req_valid     : per-requester byte pending
//   req_data      : requester i byte at [i*DATA_W +: DATA_W]
//   req_ready     : one-cycle accept pulse to the granted requester
//   tx_start      : one-cycle transmitter start pulse
//   tx_data       : registered byte, stable until frame completion
//   tx_done_tick  : end-of-frame pulse from the transmitter
//   grant_id      : current or last granted requester
//   busy          : FSM not in IDLE
//   req_lock      : only with UART_ARB_LOCK_EN; keeps the line with the
//                   current requester for multi-byte messages
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = UART_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_done_tick,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
`ifdef UART_ARB_LOCK_EN
    input  logic [N_REQ-1:0]          req_lock,
`endif
    output logic                      busy
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    uart_arb_state_e   state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  grant_id_q, grant_id_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;

    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic              relock;

    logic [DATA_W-1:0] req_bytes [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign req_bytes[i] = req_data[i*DATA_W +: DATA_W];
    end

    uart_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

`ifdef UART_ARB_LOCK_EN
    assign relock = req_lock[grant_id_q] & req_valid[grant_id_q];
`else
    assign relock = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        tx_data_d  = tx_data_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d    = START;
                    grant_id_d = pick_idx;
                    tx_data_d  = req_bytes[pick_idx];
                end
            end
            START: begin
                // tx_done_tick here belongs to no frame of ours; ignore it
                state_d = WAIT;
            end
            WAIT: begin
                if (tx_done_tick) begin
                    if (relock) begin
                        // Same requester keeps the line; pointer stays put
                        state_d   = START;
                        tx_data_d = req_bytes[grant_id_q];
                    end else begin
                        state_d  = IDLE;
                        rr_ptr_d = IDX_W'(rr_wrap_inc(32'(grant_id_q), N_REQ));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // Outputs decode registered state only, so they cannot glitch
    always_comb begin
        req_ready = '0;
        if (state_q == START) begin
            req_ready[grant_id_q] = 1'b1;
        end
    end

    assign tx_start = (state_q == START);
    assign busy     = (state_q != IDLE);
    assign tx_data  = tx_data_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (N_REQ=4, DATA_W=8).
// A small transmitter model returns tx_done_tick 20 cycles after tx_start;
// manual ticks cover the spurious-tick and lock cases.
module tb_uart_tx_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           tx_start;
    logic [W-1:0]   tx_data;
    logic           tx_done_tick;
    logic [1:0]     grant_id;
    logic           busy;
    logic [N-1:0]   req_lock;

    logic model_en;
    logic model_done;
    logic manual_tick;
    int   model_cnt;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign tx_done_tick = model_done | manual_tick;

    // Transmitter model: done pulse lands 20 cycles after the tx_start cycle
    always @(posedge clk) begin
        if (!rst_n || !model_en) begin
            model_cnt  <= 0;
            model_done <= 1'b0;
        end else begin
            model_done <= 1'b0;
            if (tx_start) begin
                model_cnt <= 19;
            end else if (model_cnt > 0) begin
                model_cnt <= model_cnt - 1;
                if (model_cnt == 1) model_done <= 1'b1;
            end
        end
    end

    uart_tx_arbiter #(
        .N_REQ  (N),
        .DATA_W (W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_done_tick (tx_done_tick),
        .grant_id     (grant_id),
`ifdef UART_ARB_LOCK_EN
        .req_lock     (req_lock),
`endif
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(output int at);
        int n;
        n = 0;
        step();
        while (!tx_start && n < 100) begin
            step();
            n++;
        end
        check("start_timeout", {31'd0, tx_start}, 32'd1);
        at = cyc;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic set_byte(input int i, input logic [7:0] v);
        req_data[i*W +: W] = v;
    endtask

    initial begin
        int prev;
        int now;
        int id;
        int n;

        rst_n       = 1'b0;
        model_en    = 1'b1;
        manual_tick = 1'b0;
        req_lock    = '0;
        req_valid   = 4'b1111;
        req_data    = 32'hA3A2_A1A0;

        // Reset with all requests pending
        #1;
        step(); step(); step();
        check("rst_tx_start", {31'd0, tx_start}, 32'd0);
        check("rst_req_ready", {28'd0, req_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_grant_id", {30'd0, grant_id}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);

        // First grant one cycle after release
        rst_n = 1'b1;
        step();
        check("first_tx_start", {31'd0, tx_start}, 32'd1);
        check("first_grant", {30'd0, grant_id}, 32'd0);
        check("first_ready", {28'd0, req_ready}, 32'b0001);
        check("first_data", {24'd0, tx_data}, 32'hA0);
        prev = cyc;

        // Full rotation A1, A2, A3, A0 at 22-cycle spacing
        for (int k = 1; k <= 4; k++) begin
            wait_start(now);
            id = k % 4;
            check("rr_spacing", now - prev, 32'd22);
            check("rr_grant", {30'd0, grant_id}, id);
            check("rr_data", {24'd0, tx_data}, 32'hA0 + id);
            check("rr_ready", {28'd0, req_ready}, 32'd1 << id);
            prev = now;
            if (k == 4) req_valid = 4'b0000;
        end
        wait_idle();

        // Single requester 2, pointer is now 1
        req_valid = 4'b0100;
        set_byte(2, 8'h55);
        step();
        check("single_start", {31'd0, tx_start}, 32'd1);
        check("single_grant", {30'd0, grant_id}, 32'd2);
        check("single_data", {24'd0, tx_data}, 32'h55);
        check("single_ready", {28'd0, req_ready}, 32'b0100);
        req_valid = 4'b0000;
        step();
        check("single_ready_1cyc", {28'd0, req_ready}, 32'd0);
        check("single_busy", {31'd0, busy}, 32'd1);
        // Data change during WAIT must not reach tx_data
        set_byte(2, 8'h99);
        req_valid = 4'b0100;
        n = 0;
        while (!tx_done_tick && n < 40) begin
            step();
            n++;
        end
        req_valid = 4'b0000;
        check("done_timeout", {31'd0, tx_done_tick}, 32'd1);
        check("wait_data_held", {24'd0, tx_data}, 32'h55);
        check("busy_at_done", {31'd0, busy}, 32'd1);
        step();
        check("busy_after_done", {31'd0, busy}, 32'd0);

        // Reset during WAIT (pointer is 3, so requester 3 wins first)
        model_en = 1'b0;
        set_byte(2, 8'hA2);
        req_valid = 4'b1111;
        step();
        check("pre_abort_grant", {30'd0, grant_id}, 32'd3);
        step(); step();
        check("pre_abort_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_tx_data", {24'd0, tx_data}, 32'd0);
        check("abort_grant", {30'd0, grant_id}, 32'd0);
        check("abort_ready", {28'd0, req_ready}, 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();
        check("restart_grant", {30'd0, grant_id}, 32'd0);
        check("restart_ready", {28'd0, req_ready}, 32'b0001);
        check("restart_data", {24'd0, tx_data}, 32'hA0);
        req_valid = 4'b0000;

        // Clean reset, then spurious tick in IDLE must not move the pointer
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        manual_tick = 1'b1;
        step();
        manual_tick = 1'b0;
        check("spur_idle_busy", {31'd0, busy}, 32'd0);
        req_valid = 4'b0011;
        step();
        check("spur_ptr_grant", {30'd0, grant_id}, 32'd0);
        check("spur_ptr_start", {31'd0, tx_start}, 32'd1);
        // Tick during START is ignored: FSM still goes to WAIT
        manual_tick = 1'b1;
        step();
        manual_tick = 1'b0;
        check("spur_start_busy", {31'd0, busy}, 32'd1);
        check("spur_start_nostart", {31'd0, tx_start}, 32'd0);
        // Real tick in WAIT returns to IDLE and rotates to requester 1
        manual_tick = 1'b1;
        step();
        manual_tick = 1'b0;
        check("wait_tick_idle", {31'd0, busy}, 32'd0);
        step();
        check("rotate_grant", {30'd0, grant_id}, 32'd1);
        check("rotate_data", {24'd0, tx_data}, 32'hA1);
        req_valid = 4'b0000;
        step();
        manual_tick = 1'b1;
        step();
        manual_tick = 1'b0;
        check("rotate_idle", {31'd0, busy}, 32'd0);

`ifdef UART_ARB_LOCK_EN
        // Requester 1 sends three locked bytes, then requester 0 gets the line
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req_lock  = 4'b0010;
        req_valid = 4'b0010;
        set_byte(1, 8'hC1);
        step();
        check("lock_b1_grant", {30'd0, grant_id}, 32'd1);
        check("lock_b1_data", {24'd0, tx_data}, 32'hC1);
        req_valid = 4'b0011;
        set_byte(1, 8'hC2);
        step();
        manual_tick = 1'b1;
        step();
        manual_tick = 1'b0;
        check("lock_b2_start", {31'd0, tx_start}, 32'd1);
        check("lock_b2_grant", {30'd0, grant_id}, 32'd1);
        check("lock_b2_data", {24'd0, tx_data}, 32'hC2);
        check("lock_b2_ready", {28'd0, req_ready}, 32'b0010);
        set_byte(1, 8'hC3);
        step();
        manual_tick = 1'b1;
        step();
        manual_tick = 1'b0;
        check("lock_b3_start", {31'd0, tx_start}, 32'd1);
        check("lock_b3_data", {24'd0, tx_data}, 32'hC3);
        req_valid = 4'b0001;
        step();
        manual_tick = 1'b1;
        step();
        manual_tick = 1'b0;
        check("lock_end_idle", {31'd0, busy}, 32'd0);
        step();
        check("lock_next_grant", {30'd0, grant_id}, 32'd0);
        check("lock_next_data", {24'd0, tx_data}, 32'hA0);
        req_valid = 4'b0000;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares a single UART transmitter between `N_REQ` byte-producing requesters. It accepts one byte at a time from the winning requester over a valid/ready handshake and issues a one-cycle start pulse to the transmitter. It then holds the transmitter until the transmitter reports frame completion. It sits between the requester blocks and the UART TX datapath, which runs on the same 16x-tick baud infrastructure as the receiver.

## Interface
- `N_REQ`, default 4: number of requesters, range 2–8.
- `DATA_W`, default 8: byte width.
- `clk`  in  1: single system clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  N_REQ: requester i has a byte pending. Held until `req_ready[i]`.
- `req_data`  in  N_REQ*DATA_W: byte of requester i, at bits `[i*DATA_W +: DATA_W]`.
- `req_ready`  out  N_REQ: one-cycle accept pulse. At most one bit is set at a time.
- `tx_start`  out  1: one-cycle pulse; starts the transmitter on `tx_data`.
- `tx_data`  out  DATA_W: registered byte. Stable from `tx_start` until completion.
- `tx_done_tick`  in  1: one-cycle pulse from the transmitter at the end of the stop bit.
- `grant_id`  out  $clog2(N_REQ): index of the current or last granted requester.
- `busy`  out  1: high whenever the FSM is not in IDLE.
- `req_lock`  in  N_REQ: present only with `UART_ARB_LOCK_EN`.

## Operation
- FSM has three states:
  - IDLE: if any `req_valid` bit is set, pick winner g and go to START. Otherwise stay in IDLE.
  - START: go to WAIT unconditionally.
  - WAIT: on `tx_done_tick`, go to IDLE (see lock exception under Configuration). Otherwise stay in WAIT.
- Winner selection: g is the first set `req_valid` bit, scanning upward from `rr_ptr` with wrap from N_REQ-1 to 0.
- Clock edge that leaves IDLE: latch `tx_data <= req_data[g]` and `grant_id <= g`.
- During START: `tx_start` = 1 and `req_ready[g]` = 1. Both are decoded from registered state, so they are glitch-free.
- Pointer update: on `tx_done_tick` in WAIT, `rr_ptr <= (grant_id == N_REQ-1) ? 0 : grant_id + 1`.
- A requester that deasserts `req_valid` before it is granted simply does not compete. There is no sticky request.
- `tx_done_tick` in IDLE or START is ignored, and the pointer does not move.
- Changes to `req_valid` or `req_data` while in START or WAIT have no effect on the current transfer.
- `busy` = (state != IDLE).

## Timing
- Reset (asynchronous, `rst_n` = 0) forces: state = IDLE, `rr_ptr` = 0, `tx_data` = 0, `grant_id` = 0, `tx_start` = 0, `req_ready` = 0, `busy` = 0.
- Reset asserted mid-transfer aborts the transfer. No `req_ready` is issued afterwards.
- Latency: with `req_valid` sampled high in IDLE at cycle 0, `tx_start` and `req_ready` are high in cycle 1 and the FSM is in WAIT from cycle 2.
- Back-to-back transfers: `tx_done_tick` in cycle k gives IDLE in cycle k+1 and the next `tx_start` in cycle k+2.
- Throughput: one byte per transmitter frame plus 2 cycles.
- Handshake: the requester drops or advances `req_valid`/`req_data` on the cycle after `req_ready`. The byte was already captured before `req_ready` rose.

## Configuration
- `UART_ARB_LOCK_EN` undefined:
  - `req_lock` port is absent.
  - Strict round-robin: every byte ends in IDLE and the pointer rotates.
- `UART_ARB_LOCK_EN` defined:
  - `req_lock` port exists.
  - In WAIT on `tx_done_tick`, if `req_lock[grant_id]` and `req_valid[grant_id]` are both 1, the FSM goes directly to START and re-latches `req_data[grant_id]`.
  - In that case `rr_ptr` is not updated, and the next `tx_start` follows `tx_done_tick` by 1 cycle.
  - Use: multi-byte messages from one requester stay contiguous on the line.
  - Otherwise, behaviour is identical to the unlocked build.

## Structure
- Package `uart_pkg`:
  - state enum `{IDLE, START, WAIT}`, 2-bit encoding;
  - `UART_DATA_W` = 8;
  - `UART_MAX_REQ` = 8.
- Sub-module `uart_rr_pick`: combinational rotating priority encoder.
  - Inputs: `req` [N_REQ], `ptr`.
  - Outputs: `gnt_idx`, `any`.
- The arbiter holds the FSM, `rr_ptr` and the output registers.

## Test plan
- Reset with `req_valid` = 4'b1111 held → all outputs 0. After release, first grant is id 0 with `tx_start` 1 cycle after release-plus-sample.
- `req_valid` = 4'b1111 with data 0xA0..0xA3, transmitter model returning `tx_done_tick` 20 cycles after `tx_start` → bytes A0, A1, A2, A3, A0, with successive `tx_start` pulses 22 cycles apart.
- `req_valid` = 4'b0100 with data 0x55 → `grant_id` = 2, `tx_data` = 0x55, `req_ready` = 4'b0100 for exactly 1 cycle. `busy` falls 1 cycle after `tx_done_tick`.
- Spurious `tx_done_tick` in IDLE, plus `req_data` changed during WAIT → no state change, `rr_ptr` unchanged, `tx_data` held.
- `rst_n` pulsed low during WAIT → outputs 0 immediately. No `req_ready` is issued for the aborted requester, and arbitration restarts from `rr_ptr` = 0.
- With `UART_ARB_LOCK_EN`: `req_lock[1]` = 1, `req_valid` = 4'b0011, requester 1 sends 3 bytes → three consecutive grants to id 1, then id 0. Re-grant `tx_start` occurs 1 cycle after `tx_done_tick`.
